sr_pattern_serializer: RTL and testbench
========================================

Name: sr_pattern_serializer

Overview:
- Transmit-side counterpart of the 7-bit serial pattern detector.
- Latches a WIDTH-bit pattern on a start request and shifts it out MSB-first, one bit per BIT_CYCLES clocks.
- Each bit carries a one-cycle valid strobe, so dout/dout_valid drive a detector's din/enable directly.
- Used for on-board self-test: after WIDTH strobes the detector's shift register equals the sent pattern.
- Optional repeat mode with an inter-frame gap.

Parameters:
- WIDTH, 7: pattern length in bits; minimum 2.
- BIT_CYCLES, 4: clock cycles per bit period; minimum 1. 1 gives back-to-back strobes.
- GAP_CYCLES, 8: idle cycles between done and the next frame's first strobe in repeat mode; minimum 1.

Ports:
- clk  in  1: system clock; all logic on posedge.
- reset  in  1: synchronous, active-high reset.
- start  in  1: frame request; level sampled each cycle, accepted only in IDLE.
- pattern  in  WIDTH: pattern to send; latched on the accept edge.
- repeat_en  in  1: if high at end of frame, resend the latched pattern after the gap.
- dout  out  1: current serial bit; held stable for its whole bit period.
- dout_valid  out  1: one-cycle strobe marking a new bit on dout.
- bit_idx  out  $clog2(WIDTH): index of the bit on dout, WIDTH-1 down to 0.
- busy  out  1: high in SHIFT and GAP.
- done  out  1: one-cycle pulse at the end of each frame.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; shift register and counters cleared.
  - dout=0, dout_valid=0, bit_idx=0, busy=0, done=0.
  - Reset mid-frame aborts immediately: no done pulse, no further strobes.
- All outputs are registered.
- IDLE:
  - start=1 at edge E0: load shreg=pattern, bits_left=WIDTH-1, bit counter cnt=0, go to SHIFT.
  - In the cycle after E0: dout=pattern[WIDTH-1], dout_valid=1, bit_idx=WIDTH-1, busy=1.
- SHIFT:
  - cnt increments each cycle; dout_valid is 0 except on bit boundaries.
  - When cnt reaches BIT_CYCLES-1 and bits_left>0: present the next lower bit with dout_valid=1, decrement bit_idx and bits_left, cnt=0.
  - When cnt reaches BIT_CYCLES-1 and bits_left=0: done=1 for one cycle.
    - repeat_en=1 at that edge: go to GAP.
    - repeat_en=0: go to IDLE; busy drops in the same cycle done is high. dout holds the last bit.
- Strobe timing, relative to E0 = cycle 0:
  - Strobes at cycles 1, 1+BIT_CYCLES, …, 1+(WIDTH-1)*BIT_CYCLES.
  - done at cycle 1+WIDTH*BIT_CYCLES.
- GAP:
  - Counts GAP_CYCLES; busy=1, dout_valid=0.
  - The next frame's first strobe appears exactly GAP_CYCLES cycles after the done cycle, reusing the latched pattern.
  - repeat_en is sampled only at frame end; deasserting it during GAP does not cancel the pending frame.
- Boundary conditions:
  - start while busy is ignored; it is not queued.
  - start=1 held continuously restarts in the cycle after the return to IDLE, i.e. one idle cycle between frames.
  - Pattern changes after the accept edge have no effect until the next accept.
  - start and reset in the same cycle: reset wins.
- Counter widths:
  - cnt: $clog2(BIT_CYCLES) bits, minimum 1.
  - gap counter: $clog2(GAP_CYCLES+1) bits.
  - No wrap-around beyond these terminal counts.

Decomposition:
- Shared package:
  - State enum: IDLE, SHIFT, GAP.
  - DEFAULT_PATTERN = 7'b1010111, shared with the detector and top-level self-test.
  - Counter width helper constants.
- One sub-module, sr_bit_timer: a programmable cycle counter with clear/enable and a terminal-count output. It is instantiated twice, for bit-period timing and for gap timing.

Test Plan:
1. Reset, then start=1 for 1 cycle with pattern=7'b1010111, BIT_CYCLES=4.
   -> strobes at cycles 1,5,…,25 with dout sequence 1,0,1,0,1,1,1 and bit_idx 6..0; done at cycle 29; busy 1..28.
2. Same stimulus with a behavioural 7-bit detector model on dout/dout_valid.
   -> match asserted after the 7th strobe; no match after a frame with pattern=7'b1010110.
3. BIT_CYCLES=1, pattern=7'b1100101.
   -> strobes on 7 consecutive cycles 1..7 with dout 1,1,0,0,1,0,1; done at cycle 8.
4. repeat_en=1, GAP_CYCLES=8; pattern changed to 0 after the accept edge.
   -> second frame's first strobe 8 cycles after the first done, still 1010111.
   -> after repeat_en drops, exactly one more done, then IDLE.
5. start pulsed at cycles 3 and 10 during a frame.
   -> ignored; strobe count stays 7 per frame.
6. Reset asserted at cycle 12 mid-frame.
   -> next cycle: all outputs 0, state IDLE, no done pulse; a following start produces a full, clean frame.

Source files
------------

// File: rtl/sr_pattern_serializer_pkg.sv
// Shared types and constants for the serial pattern serializer and its self-test partners.
package sr_pattern_serializer_pkg;

    // Serializer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Self-test pattern shared with the 7-bit detector.
    localparam int unsigned DEFAULT_WIDTH = 7;
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_PATTERN = 7'b1010111;

    // Width of a counter that runs 0..cycles-1, never narrower than one bit.
    function automatic int unsigned bit_cnt_w(input int unsigned cycles);
        return (cycles > 1) ? unsigned'($clog2(cycles)) : 1;
    endfunction

    // Width of the inter-frame gap counter.
    function automatic int unsigned gap_cnt_w(input int unsigned cycles);
        return (cycles > 0) ? unsigned'($clog2(cycles + 1)) : 1;
    endfunction

endpackage

// File: rtl/sr_bit_timer.sv
// Saturating cycle counter with synchronous clear/enable and a terminal-count flag.
module sr_bit_timer
    import sr_pattern_serializer_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority; counting stops at the terminal value instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != term)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = (cnt_q == term);

endmodule

// File: rtl/sr_pattern_serializer.sv
// MSB-first pattern serializer with per-bit valid strobe and optional repeat with gap.
module sr_pattern_serializer
    import sr_pattern_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 7,
    parameter int unsigned BIT_CYCLES = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         pattern,
    input  logic                     repeat_en,
    output logic                     dout,
    output logic                     dout_valid,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned BC_W  = bit_cnt_w(BIT_CYCLES);
    localparam int unsigned GC_W  = gap_cnt_w(GAP_CYCLES);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [IDX_W-1:0]   bits_left_q, bits_left_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic               dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               bit_tc_c;
    logic               gap_tc_c;
    logic               accept_c;
    logic               load_c;
    logic               advance_c;
    logic               finish_c;
    logic [WIDTH-1:0]   frame_src_c;

    // Frame control decode: a load starts a frame, advance moves to the next bit, finish ends it.
    assign accept_c    = (state_q == IDLE) && start;
    assign load_c      = accept_c || ((state_q == GAP) && gap_tc_c);
    assign advance_c   = (state_q == SHIFT) && bit_tc_c && (bits_left_q != '0);
    assign finish_c    = (state_q == SHIFT) && bit_tc_c && (bits_left_q == '0);
    assign frame_src_c = accept_c ? pattern : pat_q;

    // Bit-period timer, restarted at every presented bit.
    sr_bit_timer #(
        .CNT_W (BC_W)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (load_c || advance_c),
        .en    (state_q == SHIFT),
        .term  (BC_W'(BIT_CYCLES - 1)),
        .tc_c  (bit_tc_c)
    );

    // Inter-frame gap timer, restarted at each frame end.
    sr_bit_timer #(
        .CNT_W (GC_W)
    ) u_gap_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (finish_c),
        .en    (state_q == GAP),
        .term  (GC_W'(GAP_CYCLES - 1)),
        .tc_c  (gap_tc_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE so it is never queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = SHIFT;
            SHIFT:   if (finish_c) state_d = repeat_en ? GAP : IDLE;
            GAP:     if (gap_tc_c) state_d = SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; dout and bit_idx hold between strobes.
    always_comb begin
        shreg_d      = shreg_q;
        pat_d        = pat_q;
        bits_left_d  = bits_left_q;
        bit_idx_d    = bit_idx_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        done_d       = 1'b0;
        busy_d       = (state_d != IDLE);

        if (accept_c) begin
            pat_d = pattern;
        end

        if (load_c) begin
            shreg_d      = frame_src_c;
            dout_d       = frame_src_c[WIDTH-1];
            dout_valid_d = 1'b1;
            bits_left_d  = IDX_W'(WIDTH - 1);
            bit_idx_d    = IDX_W'(WIDTH - 1);
        end else if (advance_c) begin
            // Rotate so the next lower bit lands in the MSB position.
            shreg_d      = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
            dout_d       = shreg_q[WIDTH-2];
            dout_valid_d = 1'b1;
            bits_left_d  = bits_left_q - IDX_W'(1);
            bit_idx_d    = bit_idx_q - IDX_W'(1);
        end else if (finish_c) begin
            done_d = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q      <= '0;
            pat_q        <= '0;
            bits_left_q  <= '0;
            bit_idx_q    <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            pat_q        <= pat_d;
            bits_left_q  <= bits_left_d;
            bit_idx_q    <= bit_idx_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign bit_idx    = bit_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sr_pattern_serializer.sv
// Scoreboard bench for sr_pattern_serializer: expected strobe/done events vs observed events.
module tb_sr_pattern_serializer;
    import sr_pattern_serializer_pkg::*;

    typedef struct packed {
        int         cyc;
        logic       is_done;
        logic       d;
        logic [2:0] idx;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start0 = 1'b0, rep0 = 1'b0;
    logic [6:0] pat0 = '0;
    logic       dout0, val0, busy0, done0;
    logic [2:0] idx0;
    logic       start1 = 1'b0, rep1 = 1'b0;
    logic [6:0] pat1 = '0;
    logic       dout1, val1, busy1, done1;
    logic [2:0] idx1;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   base = 0;
    ev_t  exp_q[$];
    ev_t  obs0[$];
    ev_t  obs1[$];
    ev_t  e, o;
    logic [6:0] det_sr = '0;

    sr_pattern_serializer #(.WIDTH(7), .BIT_CYCLES(4), .GAP_CYCLES(8)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .pattern(pat0), .repeat_en(rep0),
        .dout(dout0), .dout_valid(val0), .bit_idx(idx0), .busy(busy0), .done(done0)
    );

    sr_pattern_serializer #(.WIDTH(7), .BIT_CYCLES(1), .GAP_CYCLES(8)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .pattern(pat1), .repeat_en(rep1),
        .dout(dout1), .dout_valid(val1), .bit_idx(idx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record strobes and done pulses; dut0 also feeds a behavioural 7-bit detector.
    always @(negedge clk) begin
        if (val0) begin
            obs0.push_back('{cyc, 1'b0, dout0, idx0});
            det_sr = {det_sr[5:0], dout0};
        end
        if (done0) obs0.push_back('{cyc, 1'b1, 1'b0, 3'd0});
        if (val1) obs1.push_back('{cyc, 1'b0, dout1, idx1});
        if (done1) obs1.push_back('{cyc, 1'b1, 1'b0, 3'd0});
    end

    // Reference model: one frame's strobes starting at absolute cycle 'first', then done.
    task automatic push_frame(input int first, input logic [6:0] p, input int bc);
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back('{first + k * bc, 1'b0, p[6 - k], 3'(6 - k)});
        end
        exp_q.push_back('{first + 7 * bc, 1'b1, 1'b0, 3'd0});
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (dout0 !== 1'b0) begin bad++; $display("FAIL reset dout: got %b want 0", dout0); end
        total++; if (val0 !== 1'b0) begin bad++; $display("FAIL reset dout_valid: got %b want 0", val0); end
        total++; if (idx0 !== 3'd0) begin bad++; $display("FAIL reset bit_idx: got %0d want 0", idx0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy0); end
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done0); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset busy1: got %b want 0", busy1); end
        reset = 1'b0;
    endtask

    task automatic test_frame;
        obs0.delete(); exp_q.delete();
        @(negedge clk);
        pat0 = DEFAULT_PATTERN; start0 = 1'b1; base = cyc;
        push_frame(base + 1, pat0, 4);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 1) start0 = 1'b0;
            total++;
            if (busy0 !== 1'(c <= 28)) begin
                bad++; $display("FAIL frame busy c=%0d: got %b want %b", c, busy0, 1'(c <= 28));
            end
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs0.size() > 0) o = obs0.pop_front(); else o = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL frame ev: got cyc=%0d done=%b d=%b idx=%0d want cyc=%0d done=%b d=%b idx=%0d",
                         o.cyc, o.is_done, o.d, o.idx, e.cyc, e.is_done, e.d, e.idx);
            end
        end
        total++; if (obs0.size() != 0) begin bad++; $display("FAIL frame extra: got %0d want 0", obs0.size()); end
        total++;
        if (det_sr !== DEFAULT_PATTERN) begin
            bad++; $display("FAIL detector match: got %b want %b", det_sr, DEFAULT_PATTERN);
        end
    endtask

    task automatic test_detector;
        obs0.delete(); exp_q.delete();
        @(negedge clk);
        pat0 = 7'b1010110; start0 = 1'b1; base = cyc;
        push_frame(base + 1, pat0, 4);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 1) start0 = 1'b0;
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs0.size() > 0) o = obs0.pop_front(); else o = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL det_frame ev: got cyc=%0d done=%b d=%b idx=%0d want cyc=%0d done=%b d=%b idx=%0d",
                         o.cyc, o.is_done, o.d, o.idx, e.cyc, e.is_done, e.d, e.idx);
            end
        end
        total++; if (det_sr !== 7'b1010110) begin bad++; $display("FAIL det_shreg: got %b want 1010110", det_sr); end
        total++;
        if ((det_sr == DEFAULT_PATTERN) !== 1'b0) begin
            bad++; $display("FAIL det_nomatch: got %b want 0", det_sr == DEFAULT_PATTERN);
        end
    endtask

    task automatic test_fast_bits;
        obs1.delete(); exp_q.delete();
        @(negedge clk);
        pat1 = 7'b1100101; start1 = 1'b1; base = cyc;
        push_frame(base + 1, pat1, 1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) start1 = 1'b0;
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs1.size() > 0) o = obs1.pop_front(); else o = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL fast ev: got cyc=%0d done=%b d=%b idx=%0d want cyc=%0d done=%b d=%b idx=%0d",
                         o.cyc, o.is_done, o.d, o.idx, e.cyc, e.is_done, e.d, e.idx);
            end
        end
        total++; if (obs1.size() != 0) begin bad++; $display("FAIL fast extra: got %0d want 0", obs1.size()); end
    endtask

    task automatic test_repeat;
        obs0.delete(); exp_q.delete();
        @(negedge clk);
        pat0 = DEFAULT_PATTERN; rep0 = 1'b1; start0 = 1'b1; base = cyc;
        push_frame(base + 1, DEFAULT_PATTERN, 4);
        push_frame(base + 37, DEFAULT_PATTERN, 4);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 1) begin start0 = 1'b0; pat0 = 7'd0; end
            if (c == 32) rep0 = 1'b0;
            if (c == 33) begin
                total++;
                if (busy0 !== 1'b1) begin bad++; $display("FAIL repeat gap busy: got %b want 1", busy0); end
            end
        end
        #1;
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL repeat idle: got busy %b want 0", busy0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs0.size() > 0) o = obs0.pop_front(); else o = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL repeat ev: got cyc=%0d done=%b d=%b idx=%0d want cyc=%0d done=%b d=%b idx=%0d",
                         o.cyc, o.is_done, o.d, o.idx, e.cyc, e.is_done, e.d, e.idx);
            end
        end
        total++; if (obs0.size() != 0) begin bad++; $display("FAIL repeat extra: got %0d want 0", obs0.size()); end
    endtask

    task automatic test_start_while_busy;
        obs0.delete(); exp_q.delete();
        @(negedge clk);
        pat0 = DEFAULT_PATTERN; start0 = 1'b1; base = cyc;
        push_frame(base + 1, DEFAULT_PATTERN, 4);
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            start0 = (c == 3 || c == 10);
            if (c == 3) pat0 = 7'b1100101;
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs0.size() > 0) o = obs0.pop_front(); else o = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL busy_start ev: got cyc=%0d done=%b d=%b idx=%0d want cyc=%0d done=%b d=%b idx=%0d",
                         o.cyc, o.is_done, o.d, o.idx, e.cyc, e.is_done, e.d, e.idx);
            end
        end
        total++; if (obs0.size() != 0) begin bad++; $display("FAIL busy_start extra: got %0d want 0", obs0.size()); end
    endtask

    task automatic test_back_to_back;
        obs0.delete(); exp_q.delete();
        @(negedge clk);
        pat0 = DEFAULT_PATTERN; start0 = 1'b1; base = cyc;
        push_frame(base + 1, DEFAULT_PATTERN, 4);
        push_frame(base + 30, DEFAULT_PATTERN, 4);
        for (int c = 1; c <= 62; c++) begin
            @(negedge clk);
            if (c == 50) start0 = 1'b0;
            if (c == 29) begin
                total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL b2b idle gap: got busy %b want 0", busy0); end
            end
            if (c == 30) begin
                total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL b2b restart: got busy %b want 1", busy0); end
            end
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs0.size() > 0) o = obs0.pop_front(); else o = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL b2b ev: got cyc=%0d done=%b d=%b idx=%0d want cyc=%0d done=%b d=%b idx=%0d",
                         o.cyc, o.is_done, o.d, o.idx, e.cyc, e.is_done, e.d, e.idx);
            end
        end
        total++; if (obs0.size() != 0) begin bad++; $display("FAIL b2b extra: got %0d want 0", obs0.size()); end
    endtask

    task automatic test_reset_mid_frame;
        obs0.delete(); exp_q.delete();
        @(negedge clk);
        pat0 = DEFAULT_PATTERN; start0 = 1'b1; base = cyc;
        for (int k = 0; k < 3; k++) exp_q.push_back('{base + 1 + 4 * k, 1'b0, DEFAULT_PATTERN[6 - k], 3'(6 - k)});
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start0 = 1'b0;
            if (c == 12) reset = 1'b1;
            if (c == 13) begin
                total++;
                if ({dout0, val0, idx0, busy0, done0} !== 7'd0) begin
                    bad++; $display("FAIL mid_reset outputs: got %b want 0000000", {dout0, val0, idx0, busy0, done0});
                end
                start0 = 1'b1;
            end
            if (c == 14) begin
                total++;
                if ({val0, busy0} !== 2'b00) begin
                    bad++; $display("FAIL reset_vs_start: got valid/busy %b want 00", {val0, busy0});
                end
                reset = 1'b0; start0 = 1'b0;
            end
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs0.size() > 0) o = obs0.pop_front(); else o = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL mid_reset ev: got cyc=%0d done=%b d=%b idx=%0d want cyc=%0d done=%b d=%b idx=%0d",
                         o.cyc, o.is_done, o.d, o.idx, e.cyc, e.is_done, e.d, e.idx);
            end
        end
        total++; if (obs0.size() != 0) begin bad++; $display("FAIL mid_reset extra: got %0d want 0", obs0.size()); end

        // A clean frame must follow the abort.
        @(negedge clk);
        pat0 = 7'b0110011; start0 = 1'b1; base = cyc;
        push_frame(base + 1, 7'b0110011, 4);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 1) start0 = 1'b0;
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs0.size() > 0) o = obs0.pop_front(); else o = '0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL post_reset ev: got cyc=%0d done=%b d=%b idx=%0d want cyc=%0d done=%b d=%b idx=%0d",
                         o.cyc, o.is_done, o.d, o.idx, e.cyc, e.is_done, e.d, e.idx);
            end
        end
        total++; if (obs0.size() != 0) begin bad++; $display("FAIL post_reset extra: got %0d want 0", obs0.size()); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_detector();
        test_fast_bits();
        test_repeat();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
